// File: rtl/gf163_pkg.sv
// Shared constants and types for the GF(2^163) multiplier scheduler.
// Field is GF(2^163), p(x) = x^163 + x^80 + x^47 + x^9 + 1.
package gf163_pkg;

  localparam int GF_M  = 163;
  localparam int GF_PW = 2 * GF_M - 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [GF_M-1:0] a;
    logic [GF_M-1:0] b;
  } op_t;

endpackage

// File: rtl/gf163_mul_sched_rr_arb2.sv
// Two-way round-robin grant: rr picks the winner only on contention,
// so a lone requester is always granted.
module rr_arb2 (
  input  logic       en,
  input  logic       rr,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (valid == 2'b11): gnt = rr ? 2'b10 : 2'b01;
        (valid == 2'b01): gnt = 2'b01;
        (valid == 2'b10): gnt = 2'b10;
        default:          gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/gf163_mul_sched.sv
// Schedules two requesters onto one external GF(2^163) multiply-reduce
// path, holding operands stable for MUL_CYCLES cycles per product.
module gf163_mul_sched
  import gf163_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [GF_M-1:0] req0_a,
  input  logic [GF_M-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [GF_M-1:0] req1_a,
  input  logic [GF_M-1:0] req1_b,
  output logic [GF_M-1:0] mul_a,
  output logic [GF_M-1:0] mul_b,
  input  logic [GF_M-1:0] mul_prod,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [GF_M-1:0] rsp_data
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MUL_CYCLES - 1);

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t             op_q, op_d;
  logic [GF_M-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_id_q, rsp_id_d;

  logic [1:0] gnt;
  logic       idle;
  logic       hs;
  logic       last;
  logic       rsp_hs;

  assign idle   = (state_q == IDLE);
  assign hs     = |gnt;
  assign last   = (cnt_q == '0);
  assign rsp_hs = (state_q == DONE) && rsp_ready;

  rr_arb2 u_arb (
    .en    (idle),
    .rr    (rr_q),
    .valid ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (hs) begin
      op_d.a   = gnt[1] ? req1_a : req0_a;
      op_d.b   = gnt[1] ? req1_b : req0_b;
      rsp_id_d = gnt[1];
      cnt_d    = CNT_LOAD;
    end
    if (state_q == BUSY) begin
      if (last) begin
        rsp_data_d = mul_prod;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    // Next contention favours whoever was not just served.
    if (rsp_hs) begin
      rr_d = ~rsp_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  always_comb begin
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    mul_a      = op_q.a;
    mul_b      = op_q.b;
    rsp_valid  = (state_q == DONE);
    rsp_id     = rsp_id_q;
    rsp_data   = rsp_data_q;
  end

endmodule

// File: doc/gf163_mul_sched.md
GF163_MUL_SCHED -- requirements
Module: gf163_mul_sched

Interface
REQ-001 Parameter MUL_CYCLES, default 3, number of cycles operands are held stable on the shared multiplier (multicycle path); legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req0_valid  in  1  requester 0 has an operand pair.
REQ-005 req0_ready  out  1  requester 0 pair accepted this cycle.
REQ-006 req0_a, req0_b  in  163 each  requester 0 field operands, poly basis, p(x)=x^163+x^80+x^47+x^9+1.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  as REQ-004..006 for requester 1.
REQ-008 mul_a, mul_b  out  163 each  operands to shared Karatsuba multiplier + modulo reduction path.
REQ-009 mul_prod  in  163  reduced product returned combinationally by shared path.
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  consumer accepts result.
REQ-012 rsp_id  out  1  requester index owning the result.
REQ-013 rsp_data  out  163  registered reduced product mul_a*mul_b mod p(x).

Function
REQ-014 FSM states IDLE, BUSY, DONE; exactly one active.
REQ-015 IDLE: grant = valid requester; both valid -> requester selected by round-robin pointer rr (0 or 1).
REQ-016 reqN_ready SHALL be high only in IDLE and only for the granted requester; combinational from valid and rr; never both high.
REQ-017 Handshake cycle (valid & ready): operands registered into op_a/op_b, owner id registered, counter loaded with MUL_CYCLES-1, next state BUSY.
REQ-018 mul_a/mul_b SHALL be driven directly from op_a/op_b registers and change only on an accepting handshake.
REQ-019 BUSY: counter decrements each cycle; when counter==0, mul_prod captured into rsp_data, next state DONE.
REQ-020 Latency: handshake in cycle T -> rsp_valid high from cycle T+MUL_CYCLES+1.
REQ-021 DONE: rsp_valid=1; rsp_data, rsp_id stable until rsp_valid & rsp_ready; then next state IDLE and rr := ~rsp_id.
REQ-022 No request accepted in BUSY or DONE; valid held by requester without penalty; requester may drop valid before ready (no commitment).
REQ-023 Single-requester traffic SHALL be served back-to-back regardless of rr (no idle grant to absent requester).
REQ-024 Throughput with rsp_ready tied high: one result per MUL_CYCLES+2 cycles.
REQ-025 rsp_ready high outside DONE is ignored.

Reset
REQ-026 rst_n low: state IDLE, rr=0, counter=0, op_a=op_b=0, rsp_data=0, rsp_id=0, rsp_valid=0; readies follow IDLE rules with rr=0 immediately.
REQ-027 Reset mid-BUSY or mid-DONE discards in-flight operation; no result emitted after release.

Structure
REQ-028 Shared package gf163_pkg holds constant GF_M=163, product width 2*GF_M-1=325, and the FSM state enum.
REQ-029 Round-robin grant logic SHALL be one sub-module, rr_arb2; multiplier/reduction path stays external to this block.

Verification
REQ-030 Bench models mul_prod as behavioral GF(2^163) multiply-reduce with p(x); checks every result against independent model.
REQ-031 Req0 a=1, b=0x2 (x), MUL_CYCLES=3 -> rsp_valid 4 cycles after handshake, rsp_data=0x2, rsp_id=0.
REQ-032 Req1 a=x^162, b=x -> rsp_data bits {80,47,9,0} set only, rsp_id=1.
REQ-033 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; no requester starved; ready never both high.
REQ-034 rsp_ready low 10 cycles in DONE -> rsp_valid/rsp_data/rsp_id stable, no new ready, mul_a/mul_b unchanged.
REQ-035 rst_n asserted in 2nd BUSY cycle -> all outputs at reset values asynchronously, no rsp_valid after release until a new handshake.
REQ-036 MUL_CYCLES=1 and 15 builds -> latency exactly 2 and 16 cycles respectively.
